// File: rtl/psum_rearrange_pkg.sv
// Shared definitions for the ping-pong psum rearrange buffer: bank-state
// encoding, default widths and the requantisation helper.
package psum_rearrange_pkg;

  localparam int unsigned PSUM_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 3584;
  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned SHIFT_DEF  = 0;

  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_e;

  // Clamp an already-shifted psum into the signed DATA_W range; with relu the
  // lower bound becomes zero so negatives collapse to 0.
  function automatic int sat_requant(input int t, input int unsigned data_w, input bit relu);
    int hi;
    int lo;
    int r;
    hi = (1 << (data_w - 32'd1)) - 1;
    lo = relu ? 0 : -(1 << (data_w - 32'd1));
    r  = t;
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/rarr_bank.sv
// One storage bank: DEPTH x DATA_W array, single write port, registered read port.
module rarr_bank #(
  parameter int unsigned DEPTH  = 3584,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; contents are intentionally not cleared by reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; holds its value between reads so the top can reuse it.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/psum_rearrange_pingpong.sv
// Ping-pong rearrange buffer between the psum drain path and the ifmap loader.
// The producer fills bank wsel while the consumer drains bank rsel; each bank
// flips FREE->FULL on wr_last and FULL->FREE on rd_done.
// Optional build macro PSUM_REARRANGE_RELU_EN clamps negative psums to zero.
module psum_rearrange_pingpong
  import psum_rearrange_pkg::*;
#(
  parameter int unsigned PSUM_W = PSUM_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned SHIFT  = SHIFT_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [PSUM_W-1:0] wr_data,
  input  logic                     wr_last,
  output logic                     wr_ready,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_done,
  output logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     addr_err
);

`ifdef PSUM_REARRANGE_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  logic        wsel, wsel_nxt;
  logic        rsel, rsel_nxt;
  logic        last_sel, last_sel_nxt;
  bank_state_e bank_st  [2];
  bank_state_e bank_nxt [2];
  logic        wr_ready_nxt, rd_ready_nxt, rd_valid_nxt, addr_err_nxt;

  logic        wr_acc_c, wr_ok_c, rd_acc_c, rd_ok_c;
  logic [1:0]  bank_we, bank_re;
  logic signed [PSUM_W-1:0] wr_shift;
  logic [DATA_W-1:0]        wr_q;
  logic [DATA_W-1:0]        bank_q [2];

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wsel       <= 1'b0;
      rsel       <= 1'b0;
      last_sel   <= 1'b0;
      bank_st[0] <= BANK_FREE;
      bank_st[1] <= BANK_FREE;
      wr_ready   <= 1'b1;
      rd_ready   <= 1'b0;
      rd_valid   <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      wsel       <= wsel_nxt;
      rsel       <= rsel_nxt;
      last_sel   <= last_sel_nxt;
      bank_st[0] <= bank_nxt[0];
      bank_st[1] <= bank_nxt[1];
      wr_ready   <= wr_ready_nxt;
      rd_ready   <= rd_ready_nxt;
      rd_valid   <= rd_valid_nxt;
      addr_err   <= addr_err_nxt;
    end
  end

  // Acceptance, bank ownership transitions, error and requantisation.
  always_comb begin
    wsel_nxt     = wsel;
    rsel_nxt     = rsel;
    last_sel_nxt = last_sel;
    bank_nxt[0]  = bank_st[0];
    bank_nxt[1]  = bank_st[1];
    bank_we      = '0;
    bank_re      = '0;

    wr_acc_c = wr_en & wr_ready;
    wr_ok_c  = wr_acc_c & (32'(wr_addr) < DEPTH);
    rd_acc_c = rd_en & rd_ready;
    rd_ok_c  = rd_acc_c & (32'(rd_addr) < DEPTH);

    wr_shift = wr_data >>> SHIFT;
    wr_q     = DATA_W'(sat_requant(32'(wr_shift), DATA_W, RELU_EN));

    bank_we[wsel] = wr_ok_c;
    bank_re[rsel] = rd_ok_c;
    if (rd_ok_c) begin
      last_sel_nxt = rsel;
    end

    // Write and read banks are never the same bank in the same state, so
    // both transitions can apply together.
    if (wr_acc_c && wr_last) begin
      bank_nxt[wsel] = BANK_FULL;
      wsel_nxt       = ~wsel;
    end
    if (rd_done && rd_ready) begin
      bank_nxt[rsel] = BANK_FREE;
      rsel_nxt       = ~rsel;
    end

    addr_err_nxt = addr_err | (wr_acc_c & ~wr_ok_c) | (rd_acc_c & ~rd_ok_c);
    rd_valid_nxt = rd_ok_c;
    wr_ready_nxt = (bank_nxt[wsel_nxt] == BANK_FREE);
    rd_ready_nxt = (bank_nxt[rsel_nxt] == BANK_FULL);
  end

  // Read data comes from whichever bank served the most recent read.
  assign rd_data = last_sel ? bank_q[1] : bank_q[0];

  for (genvar i = 0; i < 2; i++) begin : g_bank
    rarr_bank #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_bank (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (bank_we[i]),
      .wr_addr (wr_addr),
      .wr_data (wr_q),
      .rd_en   (bank_re[i]),
      .rd_addr (rd_addr),
      .rd_data (bank_q[i])
    );
  end

endmodule

// File: tb/tb_psum_rearrange_pingpong.sv
// Scoreboard bench for the ping-pong rearrange buffer: a behavioural model of
// two banks with ownership flags predicts handshakes and read data.
module tb_psum_rearrange_pingpong;

  localparam int DEPTH   = 3584;
  localparam int SHIFT_M = 0;
  localparam int UNK     = -100000;

  logic               clock;
  logic               reset;
  logic               wr_en;
  logic [11:0]        wr_addr;
  logic signed [15:0] wr_data;
  logic               wr_last;
  logic               wr_ready;
  logic               rd_en;
  logic [11:0]        rd_addr;
  logic               rd_done;
  logic               rd_ready;
  logic signed [7:0]  rd_data;
  logic               rd_valid;
  logic               addr_err;

  psum_rearrange_pingpong dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .wr_ready (wr_ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_done  (rd_done),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .addr_err (addr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  int mem_m [2][DEPTH];
  bit full_m [2];
  bit wsel_m, rsel_m, err_m, exp_valid;
  int exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  bit mon_on  = 0;

  function automatic int requant(input int v);
    int t;
    t = v >>> SHIFT_M;
`ifdef PSUM_REARRANGE_RELU_EN
    if (t < 0) t = 0;
`endif
    if (t > 127) return 127;
    if (t < -128) return -128;
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented read against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_on) begin
        check("rd_valid", int'(rd_valid), int'(exp_valid));
        if (rd_valid) begin
          if (exp_q.size() == 0) begin
            check("rd_data_unexpected", 1, 0);
          end else begin
            int e;
            e = exp_q.pop_front();
            if (e != UNK) check("rd_data", int'(rd_data), e);
          end
        end
      end
    end
  end

  // One clock of stimulus: drive at negedge, update the model at posedge,
  // then check the handshake outputs at the following negedge.
  task automatic step(input bit we, input int wa, input int wd, input bit wl,
                      input bit re, input int ra, input bit rdn, input bit rst);
    bit wrdy, rrdy;
    reset   = rst;
    wr_en   = we;
    wr_addr = 12'(wa);
    wr_data = 16'(wd);
    wr_last = wl;
    rd_en   = re;
    rd_addr = 12'(ra);
    rd_done = rdn;
    @(posedge clock);
    if (rst) begin
      full_m[0] = 0; full_m[1] = 0;
      wsel_m = 0; rsel_m = 0; err_m = 0; exp_valid = 0;
      exp_q.delete();
    end else begin
      wrdy = !full_m[wsel_m];
      rrdy = full_m[rsel_m];
      exp_valid = 0;
      if (re && rrdy) begin
        if (ra < DEPTH) begin
          exp_q.push_back(mem_m[rsel_m][ra]);
          exp_valid = 1;
        end else err_m = 1;
      end
      if (we && wrdy) begin
        if (wa < DEPTH) mem_m[wsel_m][wa] = requant(wd);
        else err_m = 1;
        if (wl) begin
          full_m[wsel_m] = 1;
          wsel_m = !wsel_m;
        end
      end
      if (rdn && rrdy) begin
        full_m[rsel_m] = 0;
        rsel_m = !rsel_m;
      end
    end
    @(negedge clock);
    check("wr_ready", int'(wr_ready), int'(!full_m[wsel_m]));
    check("rd_ready", int'(rd_ready), int'(full_m[rsel_m]));
    check("addr_err", int'(addr_err), int'(err_m));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) mem_m[b][a] = UNK;
    reset = 1; wr_en = 0; wr_addr = '0; wr_data = '0; wr_last = 0;
    rd_en = 0; rd_addr = '0; rd_done = 0;
    @(negedge clock);
    do_reset();
    mon_on = 1;
    check("rd_data_reset", int'(rd_data), 0);
    check("rd_valid_reset", int'(rd_valid), 0);

    // Fill bank0 with its own addresses, then read back.
    for (int i = 0; i < 576; i++) step(1, i, i, (i == 575), 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 10, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, $urandom_range(0, 575), 0, 0);

    // Saturation cases into bank1, then close it: both banks full.
    step(1, 0, 300, 0, 0, 0, 0, 0);
    step(1, 1, -300, 0, 0, 0, 0, 0);
    step(1, 2, -5, 0, 1, 3, 0, 0);
    step(1, 3, 32767, 0, 0, 0, 0, 0);
    step(1, 4, -32768, 1, 0, 0, 0, 0);
    step(1, 0, 77, 0, 0, 0, 0, 0);      // dropped while both full
    step(1, 5, 77, 1, 1, 20, 0, 0);     // dropped, read served
    step(0, 0, 0, 0, 1, 11, 1, 0);      // release bank0, read from old bank
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, i, 0, 0);

    // Out-of-range write, then legal traffic with sticky error.
    step(1, DEPTH, 9, 0, 0, 0, 0, 0);
    step(1, 4095, 9, 0, 0, 0, 0, 0);
    step(1, 7, 9, 0, 1, DEPTH, 0, 0);
    step(1, DEPTH - 1, -2, 0, 1, 2, 0, 0);
    idle();

    // Simultaneous close of bank1 and release of bank0.
    do_reset();
    step(1, 0, 11, 0, 0, 0, 0, 0);
    step(1, 1, 12, 1, 0, 0, 0, 0);
    step(1, 0, 21, 0, 1, 0, 0, 0);
    step(1, 1, 22, 1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 2, 5, 0, 0, 0, 0, 0);

    // Reset during a read stream.
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    check("rd_data_after_reset", int'(rd_data), 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      int wa, ra;
      wa = ($urandom_range(0, 99) == 0) ? $urandom_range(DEPTH, 4095) : $urandom_range(0, 63);
      ra = ($urandom_range(0, 149) == 0) ? $urandom_range(DEPTH, 4095) : $urandom_range(0, 63);
      step(1'($urandom_range(0, 1)), wa, $urandom_range(0, 1023) - 512,
           ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)), ra,
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 299) == 0));
    end
    idle();
    idle();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
